// File: rtl/instr_decode_stage_pkg.sv
// Shared types for the instruction decode stage: bundle layout, operand width, fill states.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package decode_pkg;

    localparam int INSTR_W_DEF = 10;
    localparam int OP_W_DEF    = 4;
    localparam int REG_W_DEF   = 2;
    localparam int DATA_W_DEF  = 8;

    // Operand is everything below the opcode.
    function automatic int opnd_w(input int instr_w, input int op_w);
        return instr_w - op_w;
    endfunction

    localparam int OPND_W_DEF = opnd_w(INSTR_W_DEF, OP_W_DEF);

    // Decoded bundle at the default widths; the stage declares the same
    // layout with its own parameter widths for its storage.
    typedef struct packed {
        logic [OP_W_DEF-1:0]   opcode;
        logic [OPND_W_DEF-1:0] operand;
        logic [REG_W_DEF-1:0]  reg_a;
        logic [REG_W_DEF-1:0]  reg_b;
        logic [DATA_W_DEF-1:0] imm;
        logic                  illegal;
    } decode_bundle_t;

    // Occupancy of the main/skid pair.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fill_state_t;

endpackage

// File: rtl/instr_decode_stage_if.sv
// Handshake and decoded-field bus between fetch, decode stage and execute.
// Latency: n/a (wires only).
// Backpressure: carries InValid/InReady and OutValid/OutReady pairs.
interface instr_decode_stage_if
    import decode_pkg::*;
#(
    parameter int INSTR_W = 10,
    parameter int OP_W    = 4,
    parameter int REG_W   = 2,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16
);
    localparam int OPND_W = opnd_w(INSTR_W, OP_W);

    logic               InValid;
    logic               InReady;
    logic [INSTR_W-1:0] Instruction;
    logic               OutValid;
    logic               OutReady;
    logic [OP_W-1:0]    Opcode;
    logic [OPND_W-1:0]  Operand;
    logic [REG_W-1:0]   RegA;
    logic [REG_W-1:0]   RegB;
    logic [DATA_W-1:0]  Imm;
    logic               Bit1;
    logic               Bit0;
    logic               Illegal;
    logic               IllegalSeen;
    logic               ClearErr;
    logic [CNT_W-1:0]   DecodeCount;

    modport master (
        output InValid, Instruction, OutReady, ClearErr,
        input  InReady, OutValid, Opcode, Operand, RegA, RegB, Imm,
               Bit1, Bit0, Illegal, IllegalSeen, DecodeCount
    );

    modport slave (
        input  InValid, Instruction, OutReady, ClearErr,
        output InReady, OutValid, Opcode, Operand, RegA, RegB, Imm,
               Bit1, Bit0, Illegal, IllegalSeen, DecodeCount
    );

endinterface

// File: rtl/instr_decode_stage_decode_fields.sv
// Combinational instruction field splitter and immediate sign-extender.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; it has no handshake of its own.
module decode_fields
    import decode_pkg::*;
#(
    parameter int  INSTR_W = 10,
    parameter int  OP_W    = 4,
    parameter int  REG_W   = 2,
    parameter int  DATA_W  = 8,
    localparam int OPND_W  = opnd_w(INSTR_W, OP_W)
) (
    input  logic [INSTR_W-1:0] instruction,
    output logic [OP_W-1:0]    opcode,
    output logic [OPND_W-1:0]  operand,
    output logic [REG_W-1:0]   reg_a,
    output logic [REG_W-1:0]   reg_b,
    output logic [DATA_W-1:0]  imm
);

    assign opcode  = instruction[INSTR_W-1 -: OP_W];
    assign operand = instruction[OPND_W-1:0];
    assign reg_a   = operand[OPND_W-1 -: REG_W];
    assign reg_b   = operand[OPND_W-REG_W-1 -: REG_W];
    // Signed cast so the width extension replicates operand's top bit.
    assign imm     = DATA_W'($signed(operand));

endmodule

// File: rtl/instr_decode_stage.sv
// Registered instruction decode stage with a main+skid buffer, decode counter and optional illegal-opcode flag (DECODE_ILLEGAL_CHECK_EN).
// Latency: 1 cycle from accept edge to OutValid; 1 word/cycle with OutReady held high.
// Backpressure: two-entry skid; InReady is registered (low only when skid is occupied) and never depends on OutReady.
module instr_decode_stage
    import decode_pkg::*;
#(
    parameter int                  INSTR_W      = 10,
    parameter int                  OP_W         = 4,
    parameter int                  REG_W        = 2,
    parameter int                  DATA_W       = 8,
    parameter int                  CNT_W        = 16,
    parameter logic [2**OP_W-1:0]  ILLEGAL_MASK = '0
) (
    input logic                  Clock,
    input logic                  ResetN,
    instr_decode_stage_if.slave  bus
);

    localparam int OPND_W = opnd_w(INSTR_W, OP_W);

    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic [OPND_W-1:0] operand;
        logic [REG_W-1:0]  reg_a;
        logic [REG_W-1:0]  reg_b;
        logic [DATA_W-1:0] imm;
        logic              illegal;
    } bundle_t;

    logic [OP_W-1:0]   f_opcode;
    logic [OPND_W-1:0] f_operand;
    logic [REG_W-1:0]  f_reg_a;
    logic [REG_W-1:0]  f_reg_b;
    logic [DATA_W-1:0] f_imm;
    logic              in_illegal;
    bundle_t           in_bundle;
    bundle_t           main_q;
    bundle_t           skid_q;
    fill_state_t       state_q;
    fill_state_t       state_d;
    logic              accept;
    logic              consume;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;
    logic [CNT_W-1:0]  count_q;

    decode_fields #(
        .INSTR_W (INSTR_W),
        .OP_W    (OP_W),
        .REG_W   (REG_W),
        .DATA_W  (DATA_W)
    ) u_fields (
        .instruction (bus.Instruction),
        .opcode      (f_opcode),
        .operand     (f_operand),
        .reg_a       (f_reg_a),
        .reg_b       (f_reg_b),
        .imm         (f_imm)
    );

`ifdef DECODE_ILLEGAL_CHECK_EN
    assign in_illegal = ILLEGAL_MASK[f_opcode];
`else
    assign in_illegal = 1'b0;
`endif

    assign in_bundle = '{opcode: f_opcode, operand: f_operand, reg_a: f_reg_a,
                         reg_b: f_reg_b, imm: f_imm, illegal: in_illegal};

    assign accept  = bus.InValid && (state_q != FULL);
    assign consume = (state_q != EMPTY) && bus.OutReady;

    // Occupancy register.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) state_q <= EMPTY;
        else         state_q <= state_d;
    end

    // Next occupancy and which register loads from where.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d      = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (consume) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (consume) begin
                    state_d        = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Bundle storage; main holds steady while the consumer stalls.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)        main_q <= in_bundle;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= in_bundle;
        end
    end

    // Retired-decode counter, wraps naturally.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN)      count_q <= '0;
        else if (consume) count_q <= count_q + 1'b1;
    end

`ifdef DECODE_ILLEGAL_CHECK_EN
    logic seen_q;

    // Sticky illegal flag; a set in the same cycle as ClearErr wins.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN)                       seen_q <= 1'b0;
        else if (consume && main_q.illegal) seen_q <= 1'b1;
        else if (bus.ClearErr)             seen_q <= 1'b0;
    end

    assign bus.Illegal     = main_q.illegal;
    assign bus.IllegalSeen = seen_q;
`else
    logic unused_illegal_cfg;
    assign unused_illegal_cfg = ^{ILLEGAL_MASK, bus.ClearErr, main_q.illegal};
    assign bus.Illegal        = 1'b0;
    assign bus.IllegalSeen    = 1'b0;
`endif

    assign bus.InReady     = (state_q != FULL);
    assign bus.OutValid    = (state_q != EMPTY);
    assign bus.Opcode      = main_q.opcode;
    assign bus.Operand     = main_q.operand;
    assign bus.RegA        = main_q.reg_a;
    assign bus.RegB        = main_q.reg_b;
    assign bus.Imm         = main_q.imm;
    assign bus.Bit1        = main_q.operand[1];
    assign bus.Bit0        = main_q.operand[0];
    assign bus.DecodeCount = count_q;

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Registered, parametrised instruction decode stage for the single-cycle CPU datapath, replacing the fixed 10-bit combinational field splitter. It accepts raw instruction words on a valid/ready handshake and splits them into opcode, register and immediate fields. Decoded bundles are buffered in a two-entry skid buffer so fetch and execute can stall independently. The stage also counts retired decodes and optionally flags illegal opcodes.

## Interface
- INSTR_W, 10: instruction width.
- OP_W, 4: opcode width, taken from the top bits.
- REG_W, 2: width of each register-select field.
- DATA_W, 8: width of the sign-extended immediate; must satisfy DATA_W ≥ INSTR_W-OP_W.
- CNT_W, 16: decode counter width.
- ILLEGAL_MASK, all zeros (2**OP_W bits): bit k set marks opcode k illegal.

Ports:
- Clock  in  1  sole clock, rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- InValid  in  1  instruction word present.
- InReady  out  1  stage can accept a word.
- Instruction  in  INSTR_W  raw instruction word.
- OutValid  out  1  decoded bundle present.
- OutReady  in  1  consumer accepts the bundle.
- Opcode  out  OP_W  Instruction[INSTR_W-1 -: OP_W].
- Operand  out  OPND_W  Instruction[OPND_W-1:0], where OPND_W = INSTR_W-OP_W.
- RegA  out  REG_W  Operand[OPND_W-1 -: REG_W].
- RegB  out  REG_W  Operand[OPND_W-REG_W-1 -: REG_W].
- Imm  out  DATA_W  Operand sign-extended to DATA_W.
- Bit1, Bit0  out  1 each  Operand[1] and Operand[0].
- Illegal  out  1  opcode of the current bundle is marked in ILLEGAL_MASK.
- IllegalSeen  out  1  sticky illegal flag.
- ClearErr  in  1  clears IllegalSeen.
- DecodeCount  out  CNT_W  number of bundles consumed (OutValid && OutReady).

## Operation
- Storage: a main register (drives the outputs) and a skid register, each with its own valid bit.
- Accept: a word is accepted when InValid && InReady. It is decoded combinationally at the input and the decoded fields are registered.
- InReady = !skid_valid. InReady is a registered signal and never depends combinationally on OutReady.
- Transitions, with states EMPTY / ONE / FULL:
  - EMPTY + accept -> ONE (word goes to main).
  - ONE + accept, no consume -> FULL (word goes to skid).
  - ONE + accept + consume -> ONE (main reloads with the new word).
  - ONE + consume only -> EMPTY.
  - FULL + consume -> ONE (skid moves to main). No accept is possible in FULL.
- Ordering is strict FIFO. No word is ever dropped or duplicated.
- OutValid = main_valid. While OutValid && !OutReady, all output fields hold stable.
- DecodeCount increments on every consume and wraps modulo 2**CNT_W.
- Field extraction uses the widths given under Interface. Imm sign-extends from Operand[OPND_W-1].

## Timing
- Latency is 1 cycle, from the accept edge to OutValid.
- Throughput is 1 word per cycle when OutReady is held high.
- Reset (asynchronous, mid-operation included) empties both entries immediately.
- Reset values: OutValid=0, InReady=1, all field outputs=0, Illegal=0, IllegalSeen=0, DecodeCount=0.
- InReady rises in the cycle after FULL drains to ONE.
- IllegalSeen sets on the consume of an Illegal bundle. ClearErr clears it on the next edge. If ClearErr and a set occur in the same cycle, the set wins.

## Configuration
- DECODE_ILLEGAL_CHECK_EN defined: Illegal is stored per entry from ILLEGAL_MASK[opcode], and IllegalSeen behaves as described above.
- DECODE_ILLEGAL_CHECK_EN undefined: Illegal and IllegalSeen are tied to 0, ClearErr is ignored, and no mask storage is built.

## Structure
- Shared package decode_pkg:
  - decoded-bundle struct typedef (opcode, operand, regA, regB, imm, illegal);
  - the OPND_W derivation function;
  - the EMPTY/ONE/FULL state enum.
- Sub-module: decode_fields, a pure combinational field splitter and sign-extender, instantiated once at the input. The skid buffer and counter stay in the top level.

## Test plan
All scenarios use default parameters.
- Instruction 10'h2B6 with OutReady=1 -> one cycle later: Opcode=4'hA, Operand=6'h36, RegA=2'd3, RegB=2'd1, Imm=8'hF6, Bit1=1, Bit0=0.
- Back-to-back 10'h001, 10'h002, 10'h003 with OutReady=1 -> outputs appear on consecutive cycles in order, and DecodeCount=3.
- OutReady=0 while two words are sent -> InReady=0 after the second. Releasing OutReady delivers both in order with no loss.
- ResetN pulsed low while FULL -> OutValid=0 and InReady=1 immediately. DecodeCount=0.
- With DECODE_ILLEGAL_CHECK_EN and ILLEGAL_MASK bit 15 set, send 10'h3C0 -> Illegal=1 with the bundle, and IllegalSeen=1 after consume. ClearErr then returns it to 0.
- CNT_W=4, 17 consumes -> DecodeCount wraps to 1.
